// File: rtl/taxel_mux_scanner.sv
// -----------------------------------------------------------------------------
// taxel_mux_scanner
// Break-before-make sequencer for the 5-bit mux_config code of the taxel
// one-hot mux encoder. Scans channels 0..LAST_CH, holds a single channel, or
// holds one of the two test-source codes. Every channel change inserts one
// all-off gap cycle (code 25). sample_stb marks the last cycle of each dwell.
//
// Optional feature macro: TAXEL_SCAN_SKIP_MASK_EN
//   When defined, adds input skip_mask[LAST_CH:0] (latched at start); scan mode
//   visits only unmasked channels, and an all-masked scan start is ignored.
//
// Ports
//   clk          block clock
//   rst          asynchronous, active-high reset
//   start        one-cycle run request, honoured only when idle
//   stop         abort the run, honoured in any state (wins over start)
//   mode[1:0]    00 scan, 01 hold fix_ch, 10 test+local (30), 11 test only (31)
//   fix_ch[4:0]  channel held in mode 01 (values above LAST_CH map to 0)
//   dwell        cycles per channel, 0 behaves as 1
//   skip_mask    (macro only) channels to skip in scan mode
//   mux_config   registered code to the one-hot encoder
//   busy         high whenever a run is active
//   sample_stb   pulse on the last cycle of every dwell period
//   cur_ch       last code driven during a dwell
//   frame_done   pulse with sample_stb at the end of the last scanned channel
// -----------------------------------------------------------------------------
module taxel_mux_scanner #(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned LAST_CH = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [4:0]         fix_ch,
    input  logic [DWELL_W-1:0] dwell,
`ifdef TAXEL_SCAN_SKIP_MASK_EN
    input  logic [LAST_CH:0]   skip_mask,
`endif
    output logic [4:0]         mux_config,
    output logic               busy,
    output logic               sample_stb,
    output logic [4:0]         cur_ch,
    output logic               frame_done
);

    localparam int unsigned CH_W = 5;

    localparam logic [CH_W-1:0] CODE_OFF  = CH_W'(25);
    localparam logic [CH_W-1:0] CODE_TSL  = CH_W'(30);
    localparam logic [CH_W-1:0] CODE_TS   = CH_W'(31);
    localparam logic [CH_W-1:0] LAST_CODE = CH_W'(LAST_CH);

    localparam logic [1:0] MODE_SCAN = 2'b00;
    localparam logic [1:0] MODE_FIX  = 2'b01;
    localparam logic [1:0] MODE_TSL  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GAP   = 2'd1,
        S_DWELL = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [CH_W-1:0]      target_q, target_d;
    logic [DWELL_W-1:0]   reload_q, reload_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]      mux_config_q, mux_config_d;
    logic                 busy_q, busy_d;
    logic                 sample_stb_q, sample_stb_d;
    logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
    logic                 frame_done_q, frame_done_d;

    // Scan-order helpers: first channel at start, last channel of a frame,
    // successor of the current target, and whether a start may be accepted.
    logic [CH_W-1:0]      scan_first_c;
    logic [CH_W-1:0]      scan_last_c;
    logic [CH_W-1:0]      scan_next_c;
    logic                 start_ok_c;
    logic [CH_W-1:0]      start_tgt_c;

`ifdef TAXEL_SCAN_SKIP_MASK_EN
    logic [LAST_CH:0]     mask_q, mask_d;

    // Lowest clear bit of m (0 if none).
    function automatic logic [CH_W-1:0] lowest_unmasked(input logic [LAST_CH:0] m);
        logic [CH_W-1:0]  r;
        logic [LAST_CH:0] s;
        r = '0;
        for (int i = int'(LAST_CH); i >= 0; i--) begin
            s = m >> i;
            if (!s[0]) r = CH_W'(i);
        end
        return r;
    endfunction

    // Highest clear bit of m (0 if none).
    function automatic logic [CH_W-1:0] highest_unmasked(input logic [LAST_CH:0] m);
        logic [CH_W-1:0]  r;
        logic [LAST_CH:0] s;
        r = '0;
        for (int i = 0; i <= int'(LAST_CH); i++) begin
            s = m >> i;
            if (!s[0]) r = CH_W'(i);
        end
        return r;
    endfunction

    // First clear bit strictly after cur, wrapping through 0.
    function automatic logic [CH_W-1:0] next_unmasked(input logic [CH_W-1:0] cur,
                                                       input logic [LAST_CH:0] m);
        logic [CH_W-1:0]  r;
        logic [LAST_CH:0] s;
        logic             found;
        int               idx;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= int'(LAST_CH) + 1; i++) begin
            idx = (int'(cur) + i) % (int'(LAST_CH) + 1);
            s   = m >> idx;
            if (!found && !s[0]) begin
                r     = CH_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Masked scan order; the first target comes from the live mask at start.
    always_comb begin
        scan_first_c = lowest_unmasked(skip_mask);
        scan_last_c  = highest_unmasked(mask_q);
        scan_next_c  = next_unmasked(target_q, mask_q);
        start_ok_c   = !((mode == MODE_SCAN) && (&skip_mask));
    end
`else
    // Plain scan order 0..LAST_CH with wrap.
    always_comb begin
        scan_first_c = '0;
        scan_last_c  = LAST_CODE;
        scan_next_c  = (target_q >= LAST_CODE) ? '0 : target_q + CH_W'(1);
        start_ok_c   = 1'b1;
    end
`endif

    // Target code loaded when a run starts.
    always_comb begin
        start_tgt_c = scan_first_c;
        case (mode)
            MODE_SCAN: start_tgt_c = scan_first_c;
            MODE_FIX:  start_tgt_c = (fix_ch > LAST_CODE) ? '0 : fix_ch;
            MODE_TSL:  start_tgt_c = CODE_TSL;
            default:   start_tgt_c = CODE_TS;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        reload_d = reload_q;
        cnt_d    = cnt_q;
`ifdef TAXEL_SCAN_SKIP_MASK_EN
        mask_d   = mask_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && !stop && start_ok_c) begin
                    state_d  = S_GAP;
                    mode_d   = mode;
                    target_d = start_tgt_c;
                    reload_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
`ifdef TAXEL_SCAN_SKIP_MASK_EN
                    mask_d   = skip_mask;
`endif
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_DWELL;
                    cnt_d   = reload_q;
                end
            end
            S_DWELL: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (mode_q == MODE_SCAN) begin
                    state_d  = S_GAP;
                    target_d = scan_next_c;
                    cnt_d    = '0;
                end else begin
                    // Held codes re-arm the dwell without a gap.
                    cnt_d = reload_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are computed from the next state so they register in step.
        mux_config_d = (state_d == S_DWELL) ? target_d : CODE_OFF;
        busy_d       = (state_d != S_IDLE);
        sample_stb_d = (state_d == S_DWELL) && (cnt_d == '0);
        frame_done_d = sample_stb_d && (mode_q == MODE_SCAN) && (target_d == scan_last_c);
        cur_ch_d     = (state_d == S_DWELL) ? target_d : cur_ch_q;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            target_q     <= '0;
            reload_q     <= '0;
            cnt_q        <= '0;
            mux_config_q <= CODE_OFF;
            busy_q       <= 1'b0;
            sample_stb_q <= 1'b0;
            cur_ch_q     <= '0;
            frame_done_q <= 1'b0;
`ifdef TAXEL_SCAN_SKIP_MASK_EN
            mask_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            target_q     <= target_d;
            reload_q     <= reload_d;
            cnt_q        <= cnt_d;
            mux_config_q <= mux_config_d;
            busy_q       <= busy_d;
            sample_stb_q <= sample_stb_d;
            cur_ch_q     <= cur_ch_d;
            frame_done_q <= frame_done_d;
`ifdef TAXEL_SCAN_SKIP_MASK_EN
            mask_q       <= mask_d;
`endif
        end
    end

    assign mux_config = mux_config_q;
    assign busy       = busy_q;
    assign sample_stb = sample_stb_q;
    assign cur_ch     = cur_ch_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_taxel_mux_scanner.sv
// -----------------------------------------------------------------------------
// tb_taxel_mux_scanner
// Self-checking bench: a table of fixed runs, hand sequences for reset, stop,
// start/stop collision and the skip mask, and randomized runs compared against
// a stream model that expands each run into its expected per-cycle outputs.
// -----------------------------------------------------------------------------
module tb_taxel_mux_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [4:0]  fix_ch;
    logic [7:0]  dwell;
    logic [24:0] tb_mask;
    logic [4:0]  mux_config;
    logic        busy;
    logic        sample_stb;
    logic [4:0]  cur_ch;
    logic        frame_done;

    int n_total = 0;
    int n_bad   = 0;
    int exp_cur;
    int fd_cnt, fd_first, fd_last, stb_cnt;

    typedef struct {
        bit gap;
        int code;
        bit stb;
        bit fd;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        int         fch;
        int         dwell;
        int         code;
        int         period;
        int         len;
    } vec_t;

    exp_t mq[$];
    vec_t tbl[8];

    taxel_mux_scanner #(.DWELL_W(8), .LAST_CH(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .fix_ch     (fix_ch),
        .dwell      (dwell),
`ifdef TAXEL_SCAN_SKIP_MASK_EN
        .skip_mask  (tb_mask),
`endif
        .mux_config (mux_config),
        .busy       (busy),
        .sample_stb (sample_stb),
        .cur_ch     (cur_ch),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expand a run into at least n expected cycles, starting with the gap
    // cycle that follows the start edge.
    function automatic void build_model(input logic [1:0] m, input int fch,
                                        input int d, input int n);
        int   dd;
        int   ch;
        int   lo;
        int   hi;
        int   code;
        int   k;
        exp_t e;
        dd = (d == 0) ? 1 : d;
        mq.delete();
        lo = -1;
        hi = -1;
        for (int c = 0; c <= 24; c++) begin
            if (!tb_mask[c]) begin
                if (lo < 0) lo = c;
                hi = c;
            end
        end
        e.gap = 1'b1; e.code = 25; e.stb = 1'b0; e.fd = 1'b0;
        if (m == 2'b00) begin
            ch = lo;
            while (mq.size() < n) begin
                e.gap = 1'b1; e.code = 25; e.stb = 1'b0; e.fd = 1'b0;
                mq.push_back(e);
                for (int j = 0; j < dd; j++) begin
                    e.gap  = 1'b0;
                    e.code = ch;
                    e.stb  = (j == dd - 1);
                    e.fd   = (j == dd - 1) && (ch == hi);
                    mq.push_back(e);
                end
                do ch = (ch + 1) % 25; while (tb_mask[ch]);
            end
        end else begin
            if (m == 2'b01) code = (fch > 24) ? 0 : fch;
            else if (m == 2'b10) code = 30;
            else code = 31;
            mq.push_back(e);
            k = 0;
            while (mq.size() < n) begin
                e.gap  = 1'b0;
                e.code = code;
                e.stb  = ((k % dd) == dd - 1);
                e.fd   = 1'b0;
                mq.push_back(e);
                k++;
            end
        end
    endfunction

    // Start a run, compare len cycles against the model, then stop and check idle.
    task automatic run_check(input logic [1:0] m, input int fch, input int d,
                             input int len, input bit noisy);
        exp_t e;
        build_model(m, fch, d, len);
        fd_cnt = 0; fd_first = -1; fd_last = -1; stb_cnt = 0;
        mode = m; fix_ch = 5'(fch); dwell = 8'(d); start = 1'b1; stop = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            e = mq[i];
            if (!e.gap) exp_cur = e.code;
            chk("run mux_config", int'(mux_config), e.code);
            chk("run sample_stb", int'(sample_stb), int'(e.stb));
            chk("run frame_done", int'(frame_done), int'(e.fd));
            chk("run busy", int'(busy), 1);
            chk("run cur_ch", int'(cur_ch), exp_cur);
            if (frame_done) begin
                if (fd_first < 0) fd_first = i;
                fd_last = i;
                fd_cnt++;
            end
            if (sample_stb) stb_cnt++;
            if (noisy) begin
                mode   = (i % 2 == 0) ? 2'b10 : 2'($urandom);
                fix_ch = 5'($urandom);
                dwell  = 8'($urandom);
                start  = (i % 3 == 1);
            end
            if (i == len - 1) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        start = 1'b0;
        chk("stop mux_config", int'(mux_config), 25);
        chk("stop busy", int'(busy), 0);
        chk("stop sample_stb", int'(sample_stb), 0);
        chk("stop frame_done", int'(frame_done), 0);
        chk("stop cur_ch", int'(cur_ch), exp_cur);
    endtask

    initial begin
        int m, fch, d, len;
        int seq[10];

        tbl[0] = '{2'b01,  7,   0,  7,   1, 4};
        tbl[1] = '{2'b01, 29,   3,  0,   3, 6};
        tbl[2] = '{2'b01, 24,   1, 24,   1, 3};
        tbl[3] = '{2'b01, 25,   2,  0,   2, 4};
        tbl[4] = '{2'b10,  3,   2, 30,   2, 4};
        tbl[5] = '{2'b11,  0,   4, 31,   4, 8};
        tbl[6] = '{2'b00,  9,   3,  0,   3, 3};
        tbl[7] = '{2'b11,  0, 255, 31, 255, 3};

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        mode = 2'b00; fix_ch = '0; dwell = '0; tb_mask = '0;
        exp_cur = 0;

        // Reset values.
        tick(); tick();
        chk("reset mux_config", int'(mux_config), 25);
        chk("reset busy", int'(busy), 0);
        chk("reset sample_stb", int'(sample_stb), 0);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset cur_ch", int'(cur_ch), 0);
        rst = 1'b0;
        tick();
        chk("post-reset busy", int'(busy), 0);

        // Table-driven fixed runs.
        foreach (tbl[r]) begin
            mode = tbl[r].mode; fix_ch = 5'(tbl[r].fch); dwell = 8'(tbl[r].dwell);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("tbl gap mux_config", int'(mux_config), 25);
            chk("tbl gap busy", int'(busy), 1);
            chk("tbl gap sample_stb", int'(sample_stb), 0);
            tick();
            for (int k = 0; k < tbl[r].len; k++) begin
                chk("tbl mux_config", int'(mux_config), tbl[r].code);
                chk("tbl sample_stb", int'(sample_stb),
                    int'((k % tbl[r].period) == tbl[r].period - 1));
                chk("tbl cur_ch", int'(cur_ch), tbl[r].code);
                chk("tbl frame_done", int'(frame_done), 0);
                if (k == tbl[r].len - 1) stop = 1'b1;
                tick();
            end
            stop = 1'b0;
            chk("tbl stop mux_config", int'(mux_config), 25);
            chk("tbl stop busy", int'(busy), 0);
            exp_cur = tbl[r].code;
        end

        // Full scan, dwell 2: frame_done at cycle 74 and every 75 cycles after.
        run_check(2'b00, 0, 2, 152, 1'b0);
        chk("scan frame_done count", fd_cnt, 2);
        chk("scan frame_done first", fd_first, 74);
        chk("scan frame_done spacing", fd_last - fd_first, 75);
        chk("scan sample_stb count", stb_cnt, 50);

        // Stop on the cycle before a strobe: next cycle is off with no strobe.
        mode = 2'b11; dwell = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("pre-stop mux_config", int'(mux_config), 31);
        chk("pre-stop sample_stb", int'(sample_stb), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop-cut sample_stb", int'(sample_stb), 0);
        chk("stop-cut mux_config", int'(mux_config), 25);
        chk("stop-cut busy", int'(busy), 0);
        exp_cur = 31;

        // Start and stop together in idle: stop wins.
        mode = 2'b00; dwell = 8'd1; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("collide busy", int'(busy), 0);
        chk("collide mux_config", int'(mux_config), 25);
        tick();
        chk("collide busy later", int'(busy), 0);

        // Start pulses and input changes while busy are ignored.
        run_check(2'b00, 0, 1, 20, 1'b1);

        // Asynchronous reset mid-dwell.
        mode = 2'b00; dwell = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("pre-reset mux_config", int'(mux_config), 0);
        rst = 1'b1;
        #2;
        chk("async reset mux_config", int'(mux_config), 25);
        chk("async reset busy", int'(busy), 0);
        chk("async reset cur_ch", int'(cur_ch), 0);
        chk("async reset sample_stb", int'(sample_stb), 0);
        tick();
        rst = 1'b0;
        exp_cur = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("after reset busy", int'(busy), 0);
            chk("after reset mux_config", int'(mux_config), 25);
        end

`ifdef TAXEL_SCAN_SKIP_MASK_EN
        // Only channels 0..3 unmasked, dwell 1.
        seq = '{25, 0, 25, 1, 25, 2, 25, 3, 25, 0};
        tb_mask = 25'h1FFFFF0;
        mode = 2'b00; dwell = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("mask mux_config", int'(mux_config), seq[i]);
            chk("mask frame_done", int'(frame_done), int'(i == 7));
            if (i == 9) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        exp_cur = 0;

        // All channels masked: scan start ignored, held modes still run.
        tb_mask = '1;
        mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        chk("all-masked busy", int'(busy), 0);
        tick();
        chk("all-masked busy later", int'(busy), 0);
        run_check(2'b01, 5, 2, 6, 1'b0);

        // Random masks with at least one channel open.
        for (int r = 0; r < 6; r++) begin
            tb_mask = 25'($urandom);
            tb_mask[$urandom_range(0, 24)] = 1'b0;
            run_check(2'b00, 0, $urandom_range(0, 3), $urandom_range(20, 120), 1'b0);
        end
        tb_mask = '0;
`else
        seq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        chk("seq table unused", seq[0] + int'(busy), 0);
`endif

        // Randomized runs against the stream model.
        for (int r = 0; r < 40; r++) begin
            m   = $urandom_range(0, 3);
            fch = $urandom_range(0, 31);
            d   = $urandom_range(0, 4);
            len = (m == 0) ? $urandom_range(1, 200) : $urandom_range(1, 30);
            run_check(2'(m), fch, d, len, 1'($urandom_range(0, 1)));
            for (int i = 0; i < $urandom_range(0, 3); i++) begin
                stop = 1'($urandom_range(0, 1));
                tick();
                stop = 1'b0;
                chk("idle busy", int'(busy), 0);
                chk("idle mux_config", int'(mux_config), 25);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/taxel_mux_scanner.md
# taxel_mux_scanner

Sequencer that drives the 5-bit `mux_config` code of the taxel one-hot mux encoder. It supports four modes: scanning the local taxel and HEM channels 0..24, holding a single channel, or holding one of the two test-source codes. Every channel change is break-before-make: one all-off gap cycle (code 25) is inserted between channels. A sample strobe marks the end of each dwell period so the downstream spike encoder knows when a channel has settled.

## Interface
Parameters:
- `DWELL_W`, 8, width of the dwell-count input.
- `LAST_CH`, 24, highest scanned channel code; scan range is 0..`LAST_CH`.

Ports:
- `clk`  in  1  block clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a run; honoured only in IDLE.
- `stop`  in  1  abort the run; honoured in any state.
- `mode`  in  2  run mode:
  - 00: scan 0..`LAST_CH`.
  - 01: hold channel `fix_ch`.
  - 10: test source plus local taxel (code 30).
  - 11: test source only (code 31).
- `fix_ch`  in  5  channel for mode 01.
- `dwell`  in  `DWELL_W`  cycles each channel is held; 0 is treated as 1.
- `mux_config`  out  5  code to the one-hot encoder; driven from a register.
- `busy`  out  1  high whenever the state is not IDLE.
- `sample_stb`  out  1  one-cycle pulse on the last cycle of each dwell period.
- `cur_ch`  out  5  equals `mux_config` during DWELL, holds its last value otherwise.
- `frame_done`  out  1  one-cycle pulse when the dwell of channel `LAST_CH` ends in mode 00.

## Operation
States: IDLE, GAP, DWELL.

- **IDLE**
  - `mux_config`=25 (all-off).
  - `start` with no `stop` latches `mode`, `fix_ch` and `dwell`, then moves to GAP.
  - `start` and `stop` in the same cycle: stop wins and the state stays IDLE.
- **GAP**
  - Lasts exactly one cycle with `mux_config`=25, then moves to DWELL with the target code loaded.
- **DWELL**
  - `mux_config` equals the target code. The dwell counter runs from max(latched dwell,1)−1 down to 0.
  - `sample_stb`=1 on the cycle the counter is 0.
  - At counter 0 in mode 00: the target advances to the next channel, wrapping from `LAST_CH` to 0, and the state moves to GAP. `frame_done` pulses with `sample_stb` when the target is `LAST_CH`.
  - At counter 0 in modes 01/10/11: the counter reloads, the state stays in DWELL, and the code is unchanged (no gap).
- **Target codes**
  - Mode 00: the first target after start is channel 0.
  - Mode 01: `fix_ch`; a value greater than `LAST_CH` is replaced by 0.
  - Modes 10/11: 30/31.
- **`stop`** in GAP or DWELL: next state is IDLE and `mux_config`=25 on the next edge. `sample_stb` and `frame_done` are suppressed in the cycle `stop` is high.
- Inputs `mode`, `fix_ch` and `dwell` are ignored while `busy`=1. A new start is required for changes to take effect.

## Timing
- Reset values: state=IDLE, `mux_config`=25, `busy`=0, `sample_stb`=0, `frame_done`=0, `cur_ch`=0, dwell counter=0.
- `start` at edge N: GAP is visible in cycle N+1, and the first channel code appears in cycle N+2.
- With dwell=D (D≥1), mode 00: each channel occupies D cycles plus 1 gap cycle, so a full frame is (`LAST_CH`+1)×(D+1) cycles.
- `sample_stb` and `frame_done` are registered and aligned with the final dwell cycle of their channel.
- Reset mid-run forces all outputs to their reset values immediately (asynchronous). The run does not resume after reset is released.

## Configuration
- Macro `TAXEL_SCAN_SKIP_MASK_EN`.
- **Defined:**
  - An extra input `skip_mask` [`LAST_CH`:0] is added and latched at `start`.
  - In mode 00, the target advances to the next unmasked channel above the current one, wrapping around. The first target is the lowest unmasked channel.
  - `frame_done` pulses at the end of the dwell of the highest unmasked channel.
  - If all bits are set, `start` in mode 00 is ignored and the state stays IDLE.
  - Modes 01/10/11 ignore the mask.
- **Undefined:** there is no port, and all channels are scanned.

## Test plan
- **Reset:** assert `rst` mid-DWELL with mode 00, dwell=3 -> `mux_config`=25 and `busy`=0 immediately. After release, stays IDLE.
- **Full scan:** mode 00, dwell=2, pulse `start` -> codes 25,0,0,25,1,1,…,24,24,25,0. `sample_stb` pulses on every second cycle of each channel. `frame_done` pulses once per 75 cycles.
- **Held channel:** mode 01, `fix_ch`=7, dwell=0 -> 25 then constant 7, with `sample_stb` high every cycle. A second run with `fix_ch`=29 -> constant 0.
- **Test codes:** mode 11, dwell=4 -> 25 then constant 31, with `sample_stb` every 4th cycle. `stop` -> 25 next cycle and no strobe in the stop cycle.
- **Start/stop collision:** `start`=`stop`=1 in IDLE -> stays IDLE. `start` while busy, with mode changed to 10 -> no effect and the scan continues.
- **Skip mask (macro on):** `skip_mask`=0x1FFFFF0, dwell=1 -> codes 25,0,25,1,25,2,25,3,25,0. `frame_done` pulses at channel 3. Mask all ones -> `start` is ignored.
